// File: rtl/pulse_meas_ctrl.sv
// Measures the synchronized high time of sig_in by sequencing an external saturating counter.
// Optional WAIT_RISE timeout is enabled by defining PULSE_MEAS_TIMEOUT_EN.
module pulse_meas_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sig_in,
  input  logic [WIDTH-1:0] count,
  input  logic             overflow,
  output logic             count_en,
  output logic             count_clr,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_sat,
  output logic             result_timeout,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_RISE, MEASURE, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;
  logic                   s;
  logic                   rise_det;
  logic                   fall_det;
  logic                   timeout_hit;
  logic                   capture_meas;
  logic                   capture_timeout;

  // Synchronizer plus history flop run in every state so edges are never stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise_det = s & ~s_prev;
  assign fall_det = ~s & s_prev;

`ifdef PULSE_MEAS_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer;

  // Timer is held at zero outside WAIT_RISE, so it restarts on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state != WAIT_RISE) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT;
  assign timeout_hit        = 1'b0;
  assign result_timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    count_en   = 1'b0;
    count_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        count_clr  = 1'b1;
        state_next = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise_det) begin
          count_en   = 1'b1;
          state_next = MEASURE;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      MEASURE: begin
        count_en = ~fall_det & ~overflow;
        if (fall_det) state_next = DONE;
      end
      DONE: begin
        if (result_valid && result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy            = (state != IDLE);
  assign capture_meas    = (state == MEASURE) && fall_det;
  assign capture_timeout = (state == WAIT_RISE) && !rise_det && timeout_hit;

  // Result fields only change on a capture, so they stay stable while valid is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_sat   <= 1'b0;
      result_valid <= 1'b0;
`ifdef PULSE_MEAS_TIMEOUT_EN
      result_timeout <= 1'b0;
`endif
    end else if (capture_meas) begin
      result       <= overflow ? {WIDTH{1'b1}} : count;
      result_sat   <= overflow;
      result_valid <= 1'b1;
`ifdef PULSE_MEAS_TIMEOUT_EN
      result_timeout <= 1'b0;
`endif
    end else if (capture_timeout) begin
      result       <= '0;
      result_sat   <= 1'b0;
      result_valid <= 1'b1;
`ifdef PULSE_MEAS_TIMEOUT_EN
      result_timeout <= 1'b1;
`endif
    end else if (state == DONE && result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_meas_ctrl.sv
// Scoreboard bench for pulse_meas_ctrl with a behavioural saturating counter alongside.
// Define PULSE_MEAS_TIMEOUT_EN for both files to exercise the timeout build.
module tb_pulse_meas_ctrl;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 50;
  localparam int MAXV    = (1 << WIDTH) - 1;

  typedef struct {
    int res;
    int sat;
    int tout;
    int ens;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sig_in = 1'b1;
  logic [WIDTH-1:0] count;
  logic             overflow;
  logic             count_en;
  logic             count_clr;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_sat;
  logic             result_timeout;
  logic             result_valid;
  logic             result_ready = 1'b1;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  pulse_meas_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_in(sig_in),
    .count(count), .overflow(overflow), .count_en(count_en), .count_clr(count_clr),
    .busy(busy), .result(result), .result_sat(result_sat),
    .result_timeout(result_timeout), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Attached counter: synchronous clear, increments when enabled, sticks at all-ones.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (count_clr) count <= '0;
    else if (count_en && count != WIDTH'(MAXV)) count <= count + 1'b1;
  end
  assign overflow = (count == WIDTH'(MAXV));

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: the width is the synchronized high time, clamped to the counter maximum.
  function automatic exp_t model(input int high);
    exp_t e;
    e.res  = (high >= MAXV) ? MAXV : high;
    e.sat  = (high >= MAXV) ? 1 : 0;
    e.tout = 0;
    e.ens  = e.res;
    return e;
  endfunction

  // Monitor: tracks counter control activity and pops the scoreboard on each handshake.
  int   en_seen = 0;
  int   clr_seen = 0;
  bit   hold_pending = 1'b0;
  int   hold_val = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      en_seen = 0;
      clr_seen = 0;
      hold_pending = 1'b0;
    end else begin
      if (count_clr) begin
        clr_seen++;
        en_seen = 0;
      end
      if (count_en) en_seen++;
      if (hold_pending && result_valid)
        checkOutput("hold_stable", {result_timeout, result_sat, result}, hold_val);
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("result", result, e.res);
          checkOutput("result_sat", result_sat, e.sat);
          checkOutput("result_timeout", result_timeout, e.tout);
          checkOutput("count_en_cycles", en_seen, e.ens);
          checkOutput("clr_pulses", clr_seen, 1);
        end
        clr_seen = 0;
      end
      hold_pending = result_valid && !result_ready;
      hold_val = {result_timeout, result_sat, result};
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) checkOutput("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Arms the block and checks the one-cycle clear; returns once WAIT_RISE has begun.
  task automatic arm();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("count_clr_after_start", count_clr, 1);
    checkOutput("busy_after_start", busy, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int high, input bit pre_high);
    if (pre_high) begin
      sig_in = 1'b1;
      wait_cycles(6);
    end
    exp_q.push_back(model(high));
    arm();
    if (pre_high) begin
      wait_cycles(3);
      sig_in = 1'b0;
      wait_cycles(4);
    end else begin
      wait_cycles($urandom_range(1, 4));
    end
    sig_in = 1'b1;
    wait_cycles(high);
    sig_in = 1'b0;
  endtask

  initial begin
    int high;
    int waited;
    exp_t te;
    // Reset with sig_in high: every output must be low.
    wait_cycles(3);
    @(negedge clk);
    checkOutput("rst_outputs", {count_en, count_clr, busy, result_valid, result_sat, result_timeout}, 0);
    checkOutput("rst_result", result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(10);
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_clr_valid", {count_clr, count_en, result_valid}, 0);
    @(posedge clk);
    #1 sig_in = 1'b0;
    wait_cycles(4);

    applyStimulus(20, 1'b0);
    wait_idle(200);
    applyStimulus(300, 1'b0);
    wait_idle(200);
    applyStimulus(5, 1'b1);
    wait_idle(200);

    for (int i = 0; i < 10; i++) begin
      high = ($urandom_range(0, 4) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 40);
      applyStimulus(high, ($urandom_range(0, 3) == 0));
      wait_idle(200);
      wait_cycles($urandom_range(0, 3));
    end

    // Consumer stalls; a start during DONE must be ignored.
    result_ready = 1'b0;
    applyStimulus(7, 1'b0);
    waited = 0;
    while (!result_valid && waited < 200) begin
      @(posedge clk);
      #1 waited++;
    end
    checkOutput("stall_valid_seen", result_valid, 1);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clk);
      checkOutput("stall_busy", busy, 1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    result_ready = 1'b1;
    wait_idle(20);
    wait_cycles(5);
    @(negedge clk);
    checkOutput("start_ignored_busy", busy, 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a measurement.
    arm();
    wait_cycles(2);
    sig_in = 1'b1;
    wait_cycles(10);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_count_en", count_en, 0);
    checkOutput("rst_mid_busy", busy, 0);
    sig_in = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(3);

`ifdef PULSE_MEAS_TIMEOUT_EN
    te.res = 0;
    te.sat = 0;
    te.tout = 1;
    te.ens = 0;
    exp_q.push_back(te);
    arm();
    waited = 0;
    while (!result_valid && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("timeout_latency", waited, TIMEOUT);
    wait_idle(20);
`else
    arm();
    wait_cycles(200);
    @(negedge clk);
    checkOutput("no_timeout_busy", busy, 1);
    checkOutput("no_timeout_valid", result_valid, 0);
    checkOutput("no_timeout_flag", result_timeout, 0);
    @(posedge clk);
    #1;
    exp_q.push_back(model(3));
    sig_in = 1'b1;
    wait_cycles(3);
    sig_in = 1'b0;
    wait_idle(50);
`endif

    wait_cycles(5);
    checkOutput("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
